// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safe_pkg
// Description : Shared definitions for the safe lock controller family.
//               Holds the controller state type, the width helpers used to
//               size tries_left and digit_idx, and the default 7-segment
//               glyphs used by the display drivers downstream.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package safe_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_SET     = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Bits needed to hold 0..max_tries inclusive.
  function automatic int try_width(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // Bits needed to hold 0..digits inclusive.
  function automatic int dig_width(input int digits);
    return $clog2(digits + 1);
  endfunction

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage
`default_nettype wire

// File: rtl/lockout_timer.sv
`default_nettype none
// ============================================================================
// Module      : lockout_timer
// Description : Down-counter that times the lockout period. A load pulse
//               starts a run of exactly CYCLES cycles; done is high in the
//               last cycle of the run.
// Ports       : clk  - system clock
//               rst  - asynchronous reset, active high
//               load - start a new run (loads CYCLES-1)
//               busy - a run is in progress
//               done - counter has reached zero during a run
// Revision    : 1.0 - initial release
// ============================================================================
module lockout_timer #(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int            CNT_W    = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = LOAD_VAL;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : safe_lock_ctrl
// Description : Multi-digit code lock with retry budget, timed lockout and
//               run-time code change. One digit is taken per key_cfm pulse,
//               digit 0 first.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               digit_in     - switch value for the next digit
//               key_cfm      - accept digit_in
//               key_clr      - discard the partially entered sequence
//               key_chg      - enter code-change mode (when unlocked)
//               key_lock     - relock (OPEN or SET)
//               unlocked     - high in OPEN and SET
//               led_ok       - pulse on correct code / committed change
//               led_err      - pulse on wrong code
//               lockout      - high during the timed lockout
//               tries_left   - remaining wrong attempts
//               digit_idx    - digits entered in the current sequence
//               change_mode  - high in SET
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module safe_lock_ctrl
  import safe_pkg::*;
#(
  parameter int                          DIGITS         = 4,
  parameter int                          DIGIT_W        = 4,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 50_000_000,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1009
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                key_cfm,
  input  logic                                key_clr,
  input  logic                                key_chg,
  input  logic                                key_lock,
  output logic                                unlocked,
  output logic                                led_ok,
  output logic                                led_err,
  output logic                                lockout,
  output logic [try_width(MAX_TRIES)-1:0]     tries_left,
  output logic [dig_width(DIGITS)-1:0]        digit_idx,
  output logic                                change_mode
);

  localparam int                 TRY_W      = try_width(MAX_TRIES);
  localparam int                 DIG_W      = dig_width(DIGITS);
  localparam int                 CODE_W     = DIGITS * DIGIT_W;
  localparam logic [TRY_W-1:0]   TRIES_FULL = TRY_W'(MAX_TRIES);
  localparam logic [DIG_W-1:0]   LAST_IDX   = DIG_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [DIG_W-1:0]    idx_q, idx_d;
  logic                mismatch_q, mismatch_d;
  logic                led_ok_q, led_ok_d;
  logic                led_err_q, led_err_d;
  logic                unlocked_q, lockout_q, change_mode_q;

  logic                act_clr, act_lock, act_chg, act_cfm;
  logic [DIGIT_W-1:0]  cur_digit;
  logic                mismatch_now;
  logic                timer_load, timer_busy, timer_done;

  // Only the highest-priority asserted key is considered each cycle; if the
  // current state does not honour it, the cycle does nothing.
  assign act_clr  = key_clr;
  assign act_lock = !key_clr && key_lock;
  assign act_chg  = !key_clr && !key_lock && key_chg;
  assign act_cfm  = !key_clr && !key_lock && !key_chg && key_cfm;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == DIG_W'(i)) cur_digit = code_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign mismatch_now = mismatch_q || (digit_in != cur_digit);

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .busy (timer_busy),
    .done (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    tries_d    = tries_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    led_ok_d   = 1'b0;
    led_err_d  = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (act_clr) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (act_cfm) begin
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!mismatch_now) begin
              led_ok_d = 1'b1;
              tries_d  = TRIES_FULL;
              state_d  = ST_OPEN;
            end else begin
              led_err_d = 1'b1;
              if (tries_q <= TRY_W'(1)) begin
                tries_d    = '0;
                state_d    = ST_LOCKOUT;
                timer_load = 1'b1;
              end else begin
                tries_d = tries_q - 1'b1;
              end
            end
          end else begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = mismatch_now;
          end
        end
      end

      ST_OPEN: begin
        if (act_lock) begin
          state_d = ST_ENTRY;
        end else if (act_chg) begin
          state_d = ST_SET;
          idx_d   = '0;
        end
      end

      ST_SET: begin
        if (act_clr) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (act_lock) begin
          state_d    = ST_ENTRY;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (act_cfm) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == DIG_W'(i)) shadow_d[i*DIGIT_W +: DIGIT_W] = digit_in;
          end
          if (idx_q == LAST_IDX) begin
            code_d   = shadow_d;
            led_ok_d = 1'b1;
            state_d  = ST_OPEN;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        // !timer_busy only matters if the timer was somehow idle here;
        // it prevents being stranded in lockout.
        if (timer_done || !timer_busy) begin
          state_d = ST_ENTRY;
          tries_d = TRIES_FULL;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ENTRY;
      code_q        <= DEFAULT_CODE;
      shadow_q      <= '0;
      tries_q       <= TRIES_FULL;
      idx_q         <= '0;
      mismatch_q    <= 1'b0;
      led_ok_q      <= 1'b0;
      led_err_q     <= 1'b0;
      unlocked_q    <= 1'b0;
      lockout_q     <= 1'b0;
      change_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      shadow_q      <= shadow_d;
      tries_q       <= tries_d;
      idx_q         <= idx_d;
      mismatch_q    <= mismatch_d;
      led_ok_q      <= led_ok_d;
      led_err_q     <= led_err_d;
      unlocked_q    <= (state_d == ST_OPEN) || (state_d == ST_SET);
      lockout_q     <= (state_d == ST_LOCKOUT);
      change_mode_q <= (state_d == ST_SET);
    end
  end

  assign unlocked    = unlocked_q;
  assign led_ok      = led_ok_q;
  assign led_err     = led_err_q;
  assign lockout     = lockout_q;
  assign tries_left  = tries_q;
  assign digit_idx   = idx_q;
  assign change_mode = change_mode_q;

endmodule
`default_nettype wire

// File: doc/safe_lock_ctrl.md
Name: safe_lock_ctrl

Overview:
- Parametrised successor to the single-code 4-bit safe lock.
- Accepts a multi-digit code entered one digit per confirm pulse and enforces a configurable retry budget.
- After the budget is exhausted it enters a timed lockout instead of locking forever; while unlocked, the code can be changed at run time.
- Sits between the debounced key/switch inputs and the LED/seven-segment display drivers.

Parameters:
- DIGITS, 4, number of digits in the code (1..8).
- DIGIT_W, 4, width of one digit in bits (switch count).
- MAX_TRIES, 3, wrong attempts allowed before lockout (1..15).
- LOCKOUT_CYCLES, 50_000_000, clk cycles spent in lockout (>=2).
- DEFAULT_CODE, 16'h1009, code loaded at reset, width DIGITS*DIGIT_W; digit 0 is the LSBs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- digit_in  in  DIGIT_W  current switch value.
- key_cfm  in  1  one-cycle debounced pulse; accepts digit_in as the next digit.
- key_clr  in  1  one-cycle pulse; discards the partially entered sequence.
- key_chg  in  1  one-cycle pulse; enters code-change mode (honoured only when unlocked).
- key_lock  in  1  one-cycle pulse; relocks (honoured in OPEN and SET).
- unlocked  out  1  high in OPEN and SET.
- led_ok  out  1  one-cycle pulse on a correct code or on a committed change.
- led_err  out  1  one-cycle pulse on a wrong code.
- lockout  out  1  high in LOCKOUT.
- tries_left  out  TRY_W  remaining attempts; TRY_W = $clog2(MAX_TRIES+1).
- digit_idx  out  DIG_W  digits entered so far in the current sequence; DIG_W = $clog2(DIGITS+1).
- change_mode  out  1  high in SET.

Behaviour:
- Reset (async, rst=1):
  - state=ENTRY; code register=DEFAULT_CODE; tries_left=MAX_TRIES; digit_idx=0; mismatch flag=0.
  - All outputs low except tries_left.
  - Reset mid-lockout or mid-change aborts it. Any uncommitted new code is lost.
- States: ENTRY, OPEN, SET, LOCKOUT.
- ENTRY:
  - Each key_cfm compares digit_in with code digit[digit_idx], ORs any mismatch into the flag, and increments digit_idx.
  - On the key_cfm that completes DIGITS digits, the result is registered at the next edge, so outputs are valid 1 cycle after that pulse. Then digit_idx=0 and the flag is cleared.
  - Correct code: led_ok pulses, tries_left=MAX_TRIES, state goes to OPEN.
  - Wrong code: led_err pulses and tries_left decrements. If it reaches 0, state goes to LOCKOUT and the timer loads LOCKOUT_CYCLES-1.
- OPEN:
  - key_chg goes to SET with digit_idx=0.
  - key_lock goes to ENTRY.
  - key_cfm is ignored.
- SET:
  - Each key_cfm writes digit_in into a shadow buffer at digit_idx.
  - On the final digit, the shadow buffer is copied to the code register, led_ok pulses, and state returns to OPEN.
  - key_lock in SET discards the shadow buffer and goes to ENTRY.
- LOCKOUT:
  - All keys are ignored and the timer decrements each cycle.
  - When the timer reaches 0: state=ENTRY, tries_left=MAX_TRIES, lockout falls. Lockout lasts exactly LOCKOUT_CYCLES cycles.
- key_clr (ENTRY or SET): digit_idx=0 and the flag is cleared. tries_left is not consumed.
- Simultaneous events, priority: key_clr > key_lock > key_chg > key_cfm. Only one key acts per cycle.
- tries_left never wraps below 0. digit_idx never exceeds DIGITS.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package safe_pkg holds:
  - the state enum (ENTRY, OPEN, SET, LOCKOUT);
  - the width helper functions for TRY_W and DIG_W;
  - the default seven-segment constants (digits 0-9, dash) for display drivers.
- Sub-module lockout_timer (parameter CYCLES; ports load, busy, done) owns the down-counter.
- Keys are debounced upstream by the existing debounce module, one instance per key.

Test Plan (DIGITS=4, DIGIT_W=4, MAX_TRIES=3, LOCKOUT_CYCLES=16, DEFAULT_CODE=16'h1009):
1. Enter 9,0,0,1 (digit0 first) with key_cfm -> 1 cycle after the 4th pulse: led_ok pulse, unlocked=1, tries_left=3, digit_idx=0.
2. Enter 9,0,0,2 -> led_err pulse, tries_left=2, unlocked=0; repeat twice -> tries_left=0, lockout=1 for exactly 16 cycles, then tries_left=3 and lockout=0.
3. During lockout pulse key_cfm with correct digits -> no state change, digit_idx stays 0.
4. Enter 9,0 then key_clr, then 9,0,0,1 -> unlock succeeds, tries_left=3 (the clear did not consume a try).
5. Unlock, key_chg, enter 5,A,3,7 -> led_ok, change_mode=0; key_lock; enter 5,A,3,7 -> unlocked; old code 9,0,0,1 -> led_err.
6. Assert rst mid-SET after 2 digits and mid-lockout -> immediately state=ENTRY, code=16'h1009, tries_left=3, lockout=0; key_cfm and key_clr in the same cycle -> clear wins.
